gtp_rx_deframer: RTL

Receive-side deframer sitting directly downstream of the GTP subsystem's core-clock RX stream (`gt2port_*`). It accepts 32-bit AXI-Stream frames of the form header / payload / trailer, validates sync byte, length and XOR checksum, and forwards only payload words to the core through a one-entry output register. Per-frame status is reported as a one-cycle pulse, and good and bad frames are counted with saturating counters.

---
 rtl/gtp_frame_pkg.sv | 31 +++
 rtl/gtp_rx_deframer_if.sv | 20 ++
 rtl/gtp_rx_deframer_out_reg.sv | 51 +++++
 rtl/gtp_rx_deframer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gtp_frame_pkg.sv
// gtp_frame_pkg
// Holds the definitions shared by the GTP receive deframer:
//   - the deframer state encoding;
//   - the frame verdict codes reported on err_code;
//   - the header field bit positions;
//   - the default sync byte.
package gtp_frame_pkg;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRAILER = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_SYNC = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  // Header layout: {sync[31:24], type[23:16], len[15:0]}
  localparam int HDR_SYNC_MSB = 31;
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_TYPE_MSB = 23;
  localparam int HDR_TYPE_LSB = 16;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_LEN_LSB  = 0;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/gtp_rx_deframer_if.sv
// gtp_rx_deframer_if
// 32-bit AXI-Stream link carrying an 8-bit frame type alongside the data.
//   tdata  : 32-bit data word
//   tvalid : word valid
//   tready : sink ready
//   tlast  : end of frame
//   ttype  : frame type (meaningful on the deframer output side only)
// The master modport drives the stream. The slave modport receives it.
interface gtp_rx_deframer_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [7:0]  ttype;

  modport master (output tdata, output tvalid, output tlast, output ttype, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input ttype, output tready);

endinterface

// File: rtl/gtp_rx_deframer_out_reg.sv
// axis_out_reg
// One-entry AXI-Stream output register carrying data, last and type.
// Ports:
//   core_clk, reset : clock and asynchronous active-high reset
//   in_valid_i      : a payload word is offered
//   in_ready_o      : register is empty or is draining this cycle
//   in_data_i       : payload data
//   in_last_i       : payload last flag
//   in_type_i       : payload frame type
//   m_axis          : downstream stream (master side)
module axis_out_reg (
  input  logic                     core_clk,
  input  logic                     reset,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_data_i,
  input  logic                     in_last_i,
  input  logic [7:0]               in_type_i,
  gtp_rx_deframer_if.master        m_axis
);

  logic        valid_q;
  logic [31:0] data_q;
  logic        last_q;
  logic [7:0]  type_q;

  // A new word may enter when the slot is empty, or when the word it holds leaves this cycle.
  assign in_ready_o = !valid_q || m_axis.tready;

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      last_q  <= 1'b0;
      type_q  <= 8'd0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
      last_q  <= in_last_i;
      type_q  <= in_type_i;
    end else if (m_axis.tready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.ttype  = type_q;

endmodule

// File: rtl/gtp_rx_deframer.sv
// gtp_rx_deframer
// Receive deframer for the GTP core-clock RX stream.
// Each frame is made of three parts:
//   - a header {sync, type, len};
//   - len payload words;
//   - an XOR trailer, which carries tlast.
// Only payload words are forwarded downstream. Each frame ends with a one-cycle verdict pulse.
// Ports:
//   core_clk, reset : clock and asynchronous active-high reset
//   s_axis          : RX stream from the GTP (slave side)
//   m_axis          : payload stream to the core (master side, includes ttype)
//   frame_done      : one-cycle pulse when a frame verdict is ready
//   frame_err       : high with frame_done when the frame was bad
//   err_code        : 0 OK, 1 BAD_SYNC, 2 LEN, 3 CSUM (held)
//   frame_type      : type of the last judged frame (held)
//   ok_cnt, err_cnt : saturating good/bad frame counters
module gtp_rx_deframer
  import gtp_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN   = 1024,
  parameter int         CNT_W     = 16
) (
  input  logic              core_clk,
  input  logic              reset,
  gtp_rx_deframer_if.slave  s_axis,
  gtp_rx_deframer_if.master m_axis,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [7:0]        frame_type,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  type_q, type_d;
  logic [1:0]  pcode_q, pcode_d;

  logic             done_q, err_q;
  logic [1:0]       code_q;
  logic [7:0]       ftype_q;
  logic [CNT_W-1:0] ok_cnt_q, err_cnt_q;

  logic        verdict;
  logic [1:0]  vcode;
  logic [7:0]  vtype;

  logic        out_ready;
  logic        s_ready;
  logic        accept;
  logic        last_cnt;

  logic [7:0]  hdr_sync;
  logic [7:0]  hdr_type;
  logic [15:0] hdr_len;

  assign hdr_sync = s_axis.tdata[HDR_SYNC_MSB:HDR_SYNC_LSB];
  assign hdr_type = s_axis.tdata[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign hdr_len  = s_axis.tdata[HDR_LEN_MSB:HDR_LEN_LSB];

  // Only PAYLOAD can back-pressure, and only when the output slot is full and not draining.
  assign s_ready       = (state_q == ST_PAYLOAD) ? out_ready : 1'b1;
  assign s_axis.tready = s_ready;
  assign accept        = s_axis.tvalid && s_ready;
  assign last_cnt      = (cnt_q == len_q - 16'd1);

  axis_out_reg u_out_reg (
    .core_clk   (core_clk),
    .reset      (reset),
    .in_valid_i ((state_q == ST_PAYLOAD) && s_axis.tvalid),
    .in_ready_o (out_ready),
    .in_data_i  (s_axis.tdata),
    .in_last_i  (last_cnt || s_axis.tlast),
    .in_type_i  (type_q),
    .m_axis     (m_axis)
  );

  // Frame parsing: next state, running XOR, payload count and the verdict for this cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    type_d  = type_q;
    pcode_d = pcode_q;
    verdict = 1'b0;
    vcode   = ERR_OK;
    vtype   = type_q;
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          type_d = hdr_type;
          len_d  = hdr_len;
          acc_d  = s_axis.tdata;
          cnt_d  = 16'd0;
          vtype  = hdr_type;
          // A header that already carries tlast is judged at once instead of discarding.
          if (hdr_sync != SYNC_BYTE) begin
            if (s_axis.tlast) begin
              verdict = 1'b1;
              vcode   = ERR_SYNC;
            end else begin
              pcode_d = ERR_SYNC;
              state_d = ST_DISCARD;
            end
          end else if (({1'b0, hdr_len} > MAX_LEN_W) || s_axis.tlast) begin
            if (s_axis.tlast) begin
              verdict = 1'b1;
              vcode   = ERR_LEN;
            end else begin
              pcode_d = ERR_LEN;
              state_d = ST_DISCARD;
            end
          end else if (hdr_len == 16'd0) begin
            state_d = ST_TRAILER;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          acc_d = acc_q ^ s_axis.tdata;
          cnt_d = cnt_q + 16'd1;
          // tlast on any payload word means the trailer is missing, so the frame is short.
          if (s_axis.tlast) begin
            verdict = 1'b1;
            vcode   = ERR_LEN;
            state_d = ST_HDR;
          end else if (last_cnt) begin
            state_d = ST_TRAILER;
          end
        end
      end
      ST_TRAILER: begin
        if (accept) begin
          if (!s_axis.tlast) begin
            pcode_d = ERR_LEN;
            state_d = ST_DISCARD;
          end else begin
            verdict = 1'b1;
            vcode   = ((acc_q ^ s_axis.tdata) == 32'd0) ? ERR_OK : ERR_CSUM;
            state_d = ST_HDR;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && s_axis.tlast) begin
          verdict = 1'b1;
          vcode   = pcode_q;
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HDR;
      acc_q   <= 32'd0;
      cnt_q   <= 16'd0;
      len_q   <= 16'd0;
      type_q  <= 8'd0;
      pcode_q <= ERR_OK;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      type_q  <= type_d;
      pcode_q <= pcode_d;
    end
  end

  // Status pulse, with the held verdict fields and saturating counters that follow the pulse.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_OK;
      ftype_q   <= 8'd0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      done_q <= verdict;
      if (verdict) begin
        err_q   <= (vcode != ERR_OK);
        code_q  <= vcode;
        ftype_q <= vtype;
      end
      if (done_q && !err_q && (ok_cnt_q != {CNT_W{1'b1}})) begin
        ok_cnt_q <= ok_cnt_q + 1'b1;
      end
      if (done_q && err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  assign frame_type = ftype_q;
  assign ok_cnt     = ok_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
